spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
Command engine between the host-written command FIFO and the SPI master on the Bus Pirate IO pins. It pops 16-bit command words and decodes them into chip-select, byte-transfer and delay actions. It runs the SPI master go/state handshake and pushes received bytes into a result FIFO that the MCU reads over the memory-controller register window. Software streams whole SPI transactions without per-byte register pokes.

Parameters:
FIFO_WIDTH, 16, command/result word width (fixed 16; the opcode field sits in bits 15:12)
CS_IDLE, 1'b1, level of cs_out when deasserted
DELAY_WIDTH, 12, width of the delay-count field
TIMEOUT_CYCLES, 1023, watchdog limit (used only with the optional feature)

Ports:
clock  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
enable  in  1  sequencer run enable (register bit)
abort  in  1  synchronous abort pulse
cmd_nempty  in  1  command FIFO has data
cmd_data  in  16  command FIFO head word
cmd_pop  out  1  one-cycle pop strobe
res_full  in  1  result FIFO full
res_shift  out  1  one-cycle push strobe
res_data  out  16  result word
spi_go  out  1  one-cycle start to SPI master
spi_data_o  out  8  byte to transmit
spi_state  in  1  SPI master busy (1) / idle (0)
spi_data_i  in  8  received byte
cs_out  out  1  chip-select drive
busy  out  1  high whenever state != IDLE
xfer_count  out  16  completed byte transfers since reset; wraps
timeout_err  out  1  sticky watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset values: all strobes 0, spi_data_o=0, res_data=0, cs_out=CS_IDLE, busy=0, xfer_count=0, timeout_err=0, state=IDLE.
- Command word: [15:12] opcode, [11:0] argument.
  - 0x1 CS_ASSERT: cs_out=!CS_IDLE.
  - 0x2 CS_DEASSERT: cs_out=CS_IDLE.
  - 0x3 XFER: transmit arg[7:0], push result.
  - 0x4 XFER_NR: transmit arg[7:0], no push.
  - 0x5 DELAY: wait arg+1 cycles.
  - Any other opcode: NOP, consumed with no effect.
- IDLE: if enable && cmd_nempty && !spi_state, latch cmd_data, pulse cmd_pop the same cycle, go to DECODE.
- DECODE, 1 cycle:
  - CS ops update cs_out here and return to IDLE.
  - XFER/XFER_NR -> GO.
  - DELAY -> DELAY with counter loaded from arg.
- GO: spi_go=1 for exactly one cycle, spi_data_o=arg[7:0] held stable until DONE -> WAIT_START.
- WAIT_START: wait for spi_state=1 -> WAIT_DONE.
- WAIT_DONE: on spi_state=0, capture spi_data_i and increment xfer_count.
  - XFER -> PUSH.
  - XFER_NR -> IDLE.
- PUSH: hold while res_full. When !res_full, res_shift=1 for one cycle with res_data={8'h00, rx byte} -> IDLE.
- DELAY: decrement each cycle; leave for IDLE on the cycle the counter reads 0. Total dwell in DELAY is arg+1 cycles.
- Minimum command-to-command spacing is 2 cycles (IDLE+DECODE) for CS/NOP.
- enable low only blocks new fetches; an in-flight command completes.
- abort, any state: next state IDLE, cs_out=CS_IDLE, no pop or push that cycle. A pending PUSH is dropped. An SPI byte already in flight finishes in the SPI master; IDLE's !spi_state guard prevents overlapping go.
- abort and a fetch condition in the same cycle: abort wins, no pop.
- Async reset mid-transfer: all state cleared immediately and cs_out returns to CS_IDLE.
- xfer_count wraps 0xFFFF -> 0x0000.

Optional Feature:
- SPI_CMD_TIMEOUT_EN defined:
  - A watchdog counts cycles spent in WAIT_START/WAIT_DONE/PUSH.
  - On exceeding TIMEOUT_CYCLES: set timeout_err (sticky until reset), deassert CS, go to IDLE.
  - Cleared on re-entry to those states.
- Undefined: no counter logic; timeout_err is constant 0.

Decomposition:
- Shared package/include: opcode constants (OP_CS_ASSERT..OP_DELAY), state encodings, command field bit positions.
- One natural sub-module: spi_cmd_delay, a loadable down-counter with a zero flag, reused for DELAY and the watchdog.

Test Plan:
- Reset: hold rst_n=0 mid-XFER -> all outputs at reset values the same cycle, cs_out=1.
- Stream 0x1000, 0x30A5, 0x2000 with SPI model loopback returning 0x5A -> cs_out falls, one spi_go with spi_data_o=0xA5, res_shift once with res_data=0x005A, cs_out rises, xfer_count=1.
- XFER_NR 0x4033 -> spi_go once, no res_shift, xfer_count increments.
- res_full=1 during XFER -> sequencer holds in PUSH with busy=1. Release res_full after 20 cycles -> exactly one res_shift, no extra cmd_pop before it.
- DELAY 0x5004 -> busy high for DECODE+5 DELAY cycles. Next pop occurs 7 cycles after the DELAY pop.
- abort asserted in WAIT_DONE with res_full=0 -> no push, cs_out=1, next command fetched only after spi_state returns 0. With SPI_CMD_TIMEOUT_EN, holding spi_state=0 forever after go -> timeout_err=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared opcodes, command-word field positions and FSM state encoding for spi_cmd_sequencer.
package spi_cmd_sequencer_pkg;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int BYTE_MSB = 7;

  localparam logic [3:0] OP_CS_ASSERT   = 4'h1;
  localparam logic [3:0] OP_CS_DEASSERT = 4'h2;
  localparam logic [3:0] OP_XFER        = 4'h3;
  localparam logic [3:0] OP_XFER_NR     = 4'h4;
  localparam logic [3:0] OP_DELAY       = 4'h5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DECODE     = 3'd1,
    ST_GO         = 3'd2,
    ST_WAIT_START = 3'd3,
    ST_WAIT_DONE  = 3'd4,
    ST_PUSH       = 3'd5,
    ST_DELAY      = 3'd6
  } state_t;

  function automatic logic [3:0] cmd_opcode(input logic [15:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/spi_cmd_delay.sv
// Loadable down-counter with a zero flag; stops at zero. Used for DELAY dwell and the watchdog.
module spi_cmd_delay #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Command FIFO -> SPI master sequencer: CS control, byte transfers with optional result push, delays.
// Optional watchdog on the SPI/push wait states is enabled with `define SPI_CMD_TIMEOUT_EN.
module spi_cmd_sequencer
  import spi_cmd_sequencer_pkg::*;
#(
  parameter int   FIFO_WIDTH     = 16,
  parameter logic CS_IDLE        = 1'b1,
  parameter int   DELAY_WIDTH    = 12,
  parameter int   TIMEOUT_CYCLES = 1023
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  abort,
  input  logic                  cmd_nempty,
  input  logic [FIFO_WIDTH-1:0] cmd_data,
  output logic                  cmd_pop,
  input  logic                  res_full,
  output logic                  res_shift,
  output logic [FIFO_WIDTH-1:0] res_data,
  output logic                  spi_go,
  output logic [7:0]            spi_data_o,
  input  logic                  spi_state,
  input  logic [7:0]            spi_data_i,
  output logic                  cs_out,
  output logic                  busy,
  output logic [15:0]           xfer_count,
  output logic                  timeout_err
);

  state_t                state_reg;
  state_t                state_next;
  logic [FIFO_WIDTH-1:0] cmd_reg;
  logic [3:0]            opcode;
  logic                  fetch;
  logic                  byte_done;
  logic                  delay_zero;
  logic                  timeout_hit;

  assign opcode = cmd_opcode(cmd_reg);
  // The !spi_state guard keeps a byte still shifting after an abort from overlapping a new go.
  assign fetch  = enable && cmd_nempty && !spi_state;
  assign byte_done = (state_reg == ST_WAIT_DONE) && !spi_state && !abort && !timeout_hit;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (fetch) state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_XFER, OP_XFER_NR: state_next = ST_GO;
          OP_DELAY:            state_next = ST_DELAY;
          default:             state_next = ST_IDLE;
        endcase
      end
      ST_GO:         state_next = ST_WAIT_START;
      ST_WAIT_START: if (spi_state) state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!spi_state) state_next = (opcode == OP_XFER) ? ST_PUSH : ST_IDLE;
      end
      ST_PUSH:       if (!res_full) state_next = ST_IDLE;
      ST_DELAY:      if (delay_zero) state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
    if (abort || timeout_hit) state_next = ST_IDLE;
  end

  always_comb begin
    cmd_pop   = (state_reg == ST_IDLE) && fetch && !abort;
    spi_go    = (state_reg == ST_GO);
    res_shift = (state_reg == ST_PUSH) && !res_full && !abort && !timeout_hit;
    busy      = (state_reg != ST_IDLE);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reg    <= '0;
      cs_out     <= CS_IDLE;
      spi_data_o <= '0;
      res_data   <= '0;
      xfer_count <= '0;
    end else begin
      if (cmd_pop) cmd_reg <= cmd_data;
      if (abort || timeout_hit) begin
        cs_out <= CS_IDLE;
      end else if (state_reg == ST_DECODE) begin
        if (opcode == OP_CS_ASSERT)   cs_out <= ~CS_IDLE;
        if (opcode == OP_CS_DEASSERT) cs_out <= CS_IDLE;
      end
      if ((state_reg == ST_DECODE) && ((opcode == OP_XFER) || (opcode == OP_XFER_NR))) begin
        spi_data_o <= cmd_reg[BYTE_MSB:0];
      end
      if (byte_done) begin
        res_data   <= {{(FIFO_WIDTH-8){1'b0}}, spi_data_i};
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

  // Loaded with arg in DECODE, so DELAY dwells arg+1 cycles (counts arg..0).
  spi_cmd_delay #(.WIDTH(DELAY_WIDTH)) u_delay (
    .clock      (clock),
    .rst_n      (rst_n),
    .load       (state_reg == ST_DECODE),
    .load_value (cmd_reg[DELAY_WIDTH-1:0]),
    .dec        (state_reg == ST_DELAY),
    .zero       (delay_zero)
  );

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

  logic in_watch;
  logic wd_zero;
  logic timeout_err_reg;

  assign in_watch = (state_reg == ST_WAIT_START) || (state_reg == ST_WAIT_DONE) ||
                    (state_reg == ST_PUSH);

  // Reloaded whenever outside the watched states; hits zero on cycle TIMEOUT_CYCLES+1 inside them.
  spi_cmd_delay #(.WIDTH(WD_WIDTH)) u_watchdog (
    .clock      (clock),
    .rst_n      (rst_n),
    .load       (!in_watch),
    .load_value (WD_WIDTH'(TIMEOUT_CYCLES)),
    .dec        (in_watch),
    .zero       (wd_zero)
  );

  assign timeout_hit = in_watch && wd_zero;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      timeout_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: FIFO and SPI master models, expected go/push queues.
// Includes a watchdog check when built with SPI_CMD_TIMEOUT_EN.
module tb_spi_cmd_sequencer;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        cmd_nempty = 1'b0;
  logic [15:0] cmd_data = 16'h0;
  logic        res_full = 1'b0;
  logic        spi_state = 1'b0;
  logic [7:0]  spi_data_i = 8'h0;
  logic        cmd_pop, res_shift, spi_go, cs_out, busy, timeout_err;
  logic [15:0] res_data, xfer_count;
  logic [7:0]  spi_data_o;

  spi_cmd_sequencer dut (
    .clock(clock), .rst_n(rst_n), .enable(enable), .abort(abort),
    .cmd_nempty(cmd_nempty), .cmd_data(cmd_data), .cmd_pop(cmd_pop),
    .res_full(res_full), .res_shift(res_shift), .res_data(res_data),
    .spi_go(spi_go), .spi_data_o(spi_data_o), .spi_state(spi_state),
    .spi_data_i(spi_data_i), .cs_out(cs_out), .busy(busy),
    .xfer_count(xfer_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct { logic [7:0] d; logic cs; } go_t;

  int          total = 0;
  int          bad = 0;
  go_t         exp_go[$];
  logic [15:0] exp_res[$];
  logic [15:0] cmd_q[$];
  int cyc = 0, pop_cnt = 0, go_cnt = 0, sh_cnt = 0, busy_cnt = 0;
  int cs_fall = 0, cs_rise = 0, last_pop_cyc = 0, prev_pop_cyc = 0;
  logic cs_prev = 1'b1;
  int spi_t = 0;
  int spi_len = 4;
  bit spi_stuck = 1'b0;
  bit m_pop, m_go;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic refresh();
    cmd_nempty = (cmd_q.size() != 0);
    cmd_data   = (cmd_q.size() != 0) ? cmd_q[0] : 16'h0;
  endtask

  task automatic push_cmd(input logic [15:0] w);
    @(posedge clock); #1;
    cmd_q.push_back(w);
    refresh();
  endtask

  task automatic wait_quiet(input string name);
    int q = 0;
    for (int i = 0; i < 400 && q < 3; i++) begin
      @(negedge clock);
      if (cmd_q.size() == 0 && !busy && !spi_state) q++;
      else q = 0;
    end
    if (q < 3) begin
      total++; bad++;
      $display("FAIL %s: design not idle within 400 cycles (busy=%0b)", name, busy);
    end
  endtask

  task automatic wait_spi_busy(input string name);
    int n = 0;
    while (!spi_state && n < 50) begin @(negedge clock); n++; end
    if (!spi_state) begin
      total++; bad++;
      $display("FAIL %s: spi_state never rose, got 0 expected 1", name);
    end
  endtask

  // FIFO and SPI master models: sample strobes at negedge, update inputs just after posedge.
  initial forever begin
    @(negedge clock);
    m_pop = cmd_pop && rst_n;
    m_go  = spi_go && rst_n;
    @(posedge clock); #1;
    if (m_pop && cmd_q.size() > 0) void'(cmd_q.pop_front());
    refresh();
    if (m_go) spi_t = spi_len;
    else if (spi_t > 0) spi_t--;
    spi_state = (spi_t > 0) && !spi_stuck;
  end

  // Monitor: pops expectations whenever the DUT presents a go or a push.
  always @(negedge clock) begin
    cyc++;
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (cs_prev && !cs_out) cs_fall++;
      if (!cs_prev && cs_out) cs_rise++;
      if (cmd_pop) begin
        pop_cnt++;
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
        chk("pop_spi_idle", {31'd0, spi_state}, 32'd0);
      end
      if (spi_go) begin
        go_cnt++;
        $display("go  data=%02h cs=%0b", spi_data_o, cs_out);
        chk("go_expected", {31'd0, exp_go.size() > 0}, 32'd1);
        if (exp_go.size() > 0) begin
          go_t e;
          e = exp_go.pop_front();
          chk("go_data", {24'd0, spi_data_o}, {24'd0, e.d});
          chk("go_cs", {31'd0, cs_out}, {31'd0, e.cs});
        end
      end
      if (res_shift) begin
        sh_cnt++;
        $display("res data=%04h", res_data);
        chk("res_expected", {31'd0, exp_res.size() > 0}, 32'd1);
        if (exp_res.size() > 0) chk("res_data", {16'd0, res_data}, {16'd0, exp_res.pop_front()});
      end
    end
    cs_prev = cs_out;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (3) @(posedge clock); #1;
    chk("rst_cs", {31'd0, cs_out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {16'd0, xfer_count}, 32'd0);
    chk("rst_strobes", {29'd0, cmd_pop, spi_go, res_shift}, 32'd0);
    chk("rst_spi_data", {24'd0, spi_data_o}, 32'd0);
    chk("rst_res_data", {16'd0, res_data}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1; enable = 1'b1; spi_data_i = 8'h5A;

    // CS assert, XFER A5 with loopback 5A, CS deassert
    exp_go.push_back('{8'hA5, 1'b0});
    exp_res.push_back(16'h005A);
    push_cmd(16'h1000); push_cmd(16'h30A5); push_cmd(16'h2000);
    wait_quiet("stream");
    chk("stream_cs", {31'd0, cs_out}, 32'd1);
    chk("stream_count", {16'd0, xfer_count}, 32'd1);
    chk("stream_cs_fall", cs_fall, 32'd1);
    chk("stream_cs_rise", cs_rise, 32'd1);
    chk("stream_go_cnt", go_cnt, 32'd1);
    chk("stream_sh_cnt", sh_cnt, 32'd1);

    // XFER_NR: byte goes out, no result push
    exp_go.push_back('{8'h33, 1'b1});
    push_cmd(16'h4033);
    wait_quiet("xfer_nr");
    chk("nr_count", {16'd0, xfer_count}, 32'd2);
    chk("nr_go_cnt", go_cnt, 32'd2);
    chk("nr_sh_cnt", sh_cnt, 32'd1);

    // Result FIFO full: sequencer parks in PUSH, next command waits
    res_full = 1'b1; spi_data_i = 8'h3C; base = pop_cnt;
    exp_go.push_back('{8'hC3, 1'b1});
    exp_res.push_back(16'h003C);
    push_cmd(16'h30C3); push_cmd(16'h1000);
    repeat (30) @(negedge clock);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_pops", pop_cnt - base, 32'd1);
    chk("full_sh_cnt", sh_cnt, 32'd1);
    chk("full_q_left", cmd_q.size(), 32'd1);
    @(posedge clock); #1 res_full = 1'b0;
    wait_quiet("full_release");
    chk("full_sh_after", sh_cnt, 32'd2);
    chk("full_pops_after", pop_cnt - base, 32'd2);
    chk("full_cs", {31'd0, cs_out}, 32'd0);
    chk("full_count", {16'd0, xfer_count}, 32'd3);
    push_cmd(16'h2000);
    wait_quiet("full_cs_off");

    // DELAY 4 followed by a NOP: 5 DELAY cycles, pops 7 apart
    busy_cnt = 0;
    push_cmd(16'h5004); push_cmd(16'h0000);
    wait_quiet("delay");
    chk("delay_pop_gap", last_pop_cyc - prev_pop_cyc, 32'd7);
    chk("delay_busy_cycles", busy_cnt, 32'd7);

    // Abort in WAIT_DONE: no push, CS released, next fetch waits for SPI idle
    spi_len = 12; spi_data_i = 8'h77; base = pop_cnt;
    exp_go.push_back('{8'hEE, 1'b0});
    push_cmd(16'h1000); push_cmd(16'h30EE); push_cmd(16'h1000);
    wait_spi_busy("abort_spi");
    repeat (3) @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    chk("abort_cs", {31'd0, cs_out}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_q_held", cmd_q.size(), 32'd1);
    wait_quiet("abort");
    spi_len = 4;
    chk("abort_count", {16'd0, xfer_count}, 32'd3);
    chk("abort_sh_cnt", sh_cnt, 32'd2);
    chk("abort_pops", pop_cnt - base, 32'd3);
    chk("abort_cs_after", {31'd0, cs_out}, 32'd0);
    push_cmd(16'h2000);
    wait_quiet("abort_cs_off");

    // Abort held while a command is available: no pop
    abort = 1'b1;
    push_cmd(16'h1000);
    repeat (3) @(posedge clock); #1;
    chk("abort_fetch_q", cmd_q.size(), 32'd1);
    abort = 1'b0;
    wait_quiet("abort_fetch");
    chk("abort_fetch_cs", {31'd0, cs_out}, 32'd0);
    push_cmd(16'h2000);
    wait_quiet("abort_fetch_off");

    // enable low blocks fetch
    enable = 1'b0;
    push_cmd(16'h1000);
    repeat (5) @(negedge clock);
    chk("disable_q", cmd_q.size(), 32'd1);
    chk("disable_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_quiet("disable");
    chk("disable_cs", {31'd0, cs_out}, 32'd0);

    // Async reset mid-transfer
    exp_go.push_back('{8'hAA, 1'b0});
    push_cmd(16'h40AA);
    wait_spi_busy("reset_spi");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", {31'd0, cs_out}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_count", {16'd0, xfer_count}, 32'd0);
    chk("mid_rst_spi_data", {24'd0, spi_data_o}, 32'd0);
    chk("mid_rst_res_data", {16'd0, res_data}, 32'd0);
    chk("mid_rst_strobes", {29'd0, cmd_pop, spi_go, res_shift}, 32'd0);
    repeat (2) @(posedge clock); #1 rst_n = 1'b1;
    wait_quiet("after_reset");
    chk("after_rst_count", {16'd0, xfer_count}, 32'd0);

`ifdef SPI_CMD_TIMEOUT_EN
    spi_stuck = 1'b1;
    exp_go.push_back('{8'h11, 1'b1});
    push_cmd(16'h3011);
    for (int i = 0; i < 1200 && !timeout_err; i++) @(negedge clock);
    chk("timeout_err", {31'd0, timeout_err}, 32'd1);
    @(negedge clock);
    chk("timeout_cs", {31'd0, cs_out}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    spi_stuck = 1'b0;
    wait_quiet("timeout");
`else
    chk("timeout_tied", {31'd0, timeout_err}, 32'd0);
`endif

    chk("go_queue_empty", exp_go.size(), 32'd0);
    chk("res_queue_empty", exp_res.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
